cam_dvp_tx: RTL and testbench
=============================

// Module: cam_dvp_tx
// PURPOSE
//  DVP camera-source emulator: produces the 8-bit parallel stream (VSYNC/HREF/data) consumed by CAM_RGB_Capture.
//  Serialises RGB565 pixels high byte first, one byte per clock, using programmable frame timing.
//  Pixels come from an upstream valid/ready stream or an internal coordinate test pattern.
//  Drives the capture path in simulation and board bring-up without a physical sensor.
// PARAMETERS
//  H_ACTIVE     640  active pixels per line (2*H_ACTIVE byte clocks with HREF high)
//  V_ACTIVE     480  active lines per frame
//  H_BLANK      144  HREF-low clocks after each line's active bytes
//  VSYNC_LINES  3    lines with VSYNC high at frame start
//  V_BACK       17   lines between VSYNC fall and first active line
//  V_FRONT      10   lines after last active line
//  LINE_CLKS = 2*H_ACTIVE+H_BLANK (derived); every line, including sync/porch lines, lasts LINE_CLKS clocks
// PORTS
//  i_clk           in   1   clock; all outputs change on the rising edge
//  i_rst_n         in   1   asynchronous active-low reset
//  i_enable        in   1   run frames while high
//  i_test_pattern  in   1   1: internal pattern, 0: i_pix_* stream (sampled at frame start)
//  i_pix_data      in   16  RGB565 pixel
//  i_pix_valid     in   1   i_pix_data valid
//  o_pix_ready     out  1   pixel accepted this cycle if i_pix_valid
//  o_vsync         out  1   frame sync, active high
//  o_href          out  1   line-valid, active high
//  o_data          out  8   byte bus
//  o_frame_done    out  1   one-cycle pulse on last clock of front porch
//  o_underflow     out  1   sticky: a pixel was needed and i_pix_valid was low
//  o_busy          out  1   high whenever not IDLE
// BEHAVIOUR
//  Reset (async): state IDLE; all outputs 0; counters 0. Reset mid-frame aborts; no resume.
//  States: IDLE -> VSYNC -> VBACK -> ACTIVE <-> HBLANK -> VFRONT -> (VSYNC | IDLE).
//  IDLE: i_enable sampled 1 at edge N -> o_vsync=1 from edge N+1; i_test_pattern latched then.
//  VSYNC: o_vsync=1 for VSYNC_LINES*LINE_CLKS clocks; VBACK: V_BACK*LINE_CLKS clocks, all outputs low.
//  ACTIVE: o_href=1 for 2*H_ACTIVE clocks; even byte = pix[15:8], odd byte = pix[7:0].
//  HBLANK: H_BLANK clocks, o_href=0; after line V_ACTIVE-1 go to VFRONT instead of ACTIVE.
//  VFRONT: V_FRONT*LINE_CLKS clocks; o_frame_done pulses on the last one; next edge: VSYNC if i_enable=1
//   (back-to-back, zero gap), else IDLE. i_enable drop mid-frame: current frame completes.
//  Frame period exactly (VSYNC_LINES+V_BACK+V_ACTIVE+V_FRONT)*LINE_CLKS clocks.
//  o_data = 8'h00 whenever o_href=0.
//  Stream mode: o_pix_ready high exactly in the cycle before each high byte appears (H_ACTIVE*V_ACTIVE per frame);
//   low at all other times and always low in test-pattern mode. Low byte is held internally for the next cycle.
//  Underflow: ready high, valid low -> pixel 16'h0000 emitted, o_underflow set; timing never stalls;
//   o_underflow cleared only by reset.
//  Test pattern pixel = {y[7:0], x[7:0]}; x = pixel index in line, y = active line index (truncated).
//  Counter widths via $clog2 of their maxima; x, y, line count reset to 0 at each VSYNC entry.
// STRUCTURE
//  Shared package/header cam_dvp_pkg: state encoding, RGB565 width (16), byte width (8).
//  Sub-module cam_dvp_timing: line-clock, line and pixel counters, state machine, emits href/vsync/
//   pixel-request/x/y; top level holds pixel mux, byte serialiser, ready/underflow logic.
// TESTING (small params: H_ACTIVE=4, V_ACTIVE=2, H_BLANK=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1; LINE_CLKS=10)
//  Test pattern, enable 1 -> vsync high 10 clks, 10 low, href bytes 00 00 00 01 00 02 00 03, 2 blank,
//   then 01 00 01 01 01 02 01 03; frame_done at clk 50; next vsync at clk 51 if enable held.
//  Stream, valid always 1, pixels FE68,0001,.. -> o_data FE,68,00,01..; 8 ready pulses/frame, each 1 clk before high byte.
//  Valid low for 3rd pixel -> bytes 00,00 in slot 3, o_underflow=1 and stays 1; slot 4 carries next pixel; timing unchanged.
//  Drop i_enable in line 0 -> frame completes, frame_done pulses, IDLE, o_busy=0, no further vsync.
//  Assert i_rst_n=0 mid-line -> all outputs 0 immediately (async); after release, idle until enable.
//  Loopback into CAM_RGB_Capture, 3 frames random stream -> captured PIXEL sequence equals sent pixels.

Source files
------------

// File: rtl/cam_dvp_pkg.sv
// Shared definitions for the DVP camera-source emulator: state encoding,
// bus widths and small helpers used by the timing core and the top level.
package cam_dvp_pkg;

    localparam int PIX_W  = 16;   // RGB565 pixel
    localparam int BYTE_W = 8;    // DVP byte bus

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFRONT = 3'd5
    } dvp_state_t;

    // Bits needed to hold the values 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Coordinate test pattern: line index in the high byte, pixel index in the low byte.
    function automatic logic [PIX_W-1:0] pattern_pixel(input logic [BYTE_W-1:0] y,
                                                       input logic [BYTE_W-1:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/cam_dvp_if.sv
// Upstream RGB565 pixel stream (valid/ready) feeding the DVP serialiser.
interface cam_dvp_if;
    import cam_dvp_pkg::*;

    logic [PIX_W-1:0] pix_data;
    logic             pix_valid;
    logic             pix_ready;

    modport master (output pix_data, output pix_valid, input pix_ready);
    modport slave  (input pix_data, input pix_valid, output pix_ready);

endinterface

// File: rtl/cam_dvp_timing.sv
// Frame timing core: line-clock and line counters plus the frame state machine.
// Sync/line-valid outputs lag the state by one clock; the pixel request is
// issued one clock ahead of the matching high byte so the top level can
// fetch the pixel in time.
module cam_dvp_timing
    import cam_dvp_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_test_pattern,
    output logic              o_vsync,
    output logic              o_href,
    output logic              o_frame_done,
    output logic              o_busy,
    output logic              o_pix_req,
    output logic              o_tp_mode,
    output logic [BYTE_W-1:0] o_pat_x,
    output logic [BYTE_W-1:0] o_pat_y
);

    localparam int LINE_CLKS = 2 * H_ACTIVE + H_BLANK;
    localparam int LCW       = cnt_w(LINE_CLKS);
    localparam int LNW       = cnt_w(max4(VSYNC_LINES, V_BACK, V_ACTIVE, V_FRONT));

    localparam logic [LCW-1:0] LC_LAST     = LCW'(LINE_CLKS - 1);
    localparam logic [LCW-1:0] LC_ACT_LAST = LCW'(2 * H_ACTIVE - 1);
    localparam logic [LNW-1:0] VS_LAST     = LNW'(VSYNC_LINES - 1);
    localparam logic [LNW-1:0] VB_LAST     = LNW'(V_BACK - 1);
    localparam logic [LNW-1:0] VA_LAST     = LNW'(V_ACTIVE - 1);
    localparam logic [LNW-1:0] VF_LAST     = LNW'(V_FRONT - 1);

    dvp_state_t     r_state;
    logic [LCW-1:0] r_lc;
    logic [LNW-1:0] r_line;
    logic           r_vsync;
    logic           r_href;
    logic           r_done;
    logic           r_busy;
    logic           r_req;
    logic           r_tp;

    logic           w_lc_last;
    logic [LCW-1:0] w_lc_inc;
    logic [LNW-1:0] w_line_inc;

    assign w_lc_last  = (r_lc == LC_LAST);
    assign w_lc_inc   = r_lc + LCW'(1);
    assign w_line_inc = r_line + LNW'(1);

    // Frame state machine; outputs registered from the current state, request from the next.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_lc    <= '0;
            r_line  <= '0;
            r_vsync <= 1'b0;
            r_href  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_req   <= 1'b0;
            r_tp    <= 1'b0;
        end else begin
            r_vsync <= (r_state == ST_VSYNC);
            r_href  <= (r_state == ST_ACTIVE);
            r_busy  <= (r_state != ST_IDLE);
            r_done  <= 1'b0;
            r_req   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_enable) begin
                        r_state <= ST_VSYNC;
                        r_lc    <= '0;
                        r_line  <= '0;
                        r_tp    <= i_test_pattern;
                    end
                end
                ST_VSYNC: begin
                    r_lc <= w_lc_inc;
                    if (w_lc_last) begin
                        r_lc <= '0;
                        if (r_line == VS_LAST) begin
                            r_state <= ST_VBACK;
                            r_line  <= '0;
                        end else begin
                            r_line <= w_line_inc;
                        end
                    end
                end
                ST_VBACK: begin
                    r_lc <= w_lc_inc;
                    if (w_lc_last) begin
                        r_lc <= '0;
                        if (r_line == VB_LAST) begin
                            r_state <= ST_ACTIVE;
                            r_line  <= '0;
                            r_req   <= 1'b1;
                        end else begin
                            r_line <= w_line_inc;
                        end
                    end
                end
                ST_ACTIVE: begin
                    r_lc <= w_lc_inc;
                    if (r_lc == LC_ACT_LAST) begin
                        r_state <= ST_HBLANK;
                    end else if (r_lc[0]) begin
                        r_req <= 1'b1;
                    end
                end
                ST_HBLANK: begin
                    r_lc <= w_lc_inc;
                    if (w_lc_last) begin
                        r_lc <= '0;
                        if (r_line == VA_LAST) begin
                            r_state <= ST_VFRONT;
                            r_line  <= '0;
                        end else begin
                            r_state <= ST_ACTIVE;
                            r_line  <= w_line_inc;
                            r_req   <= 1'b1;
                        end
                    end
                end
                ST_VFRONT: begin
                    r_lc <= w_lc_inc;
                    if (w_lc_last) begin
                        r_lc <= '0;
                        if (r_line == VF_LAST) begin
                            r_done <= 1'b1;
                            r_line <= '0;
                            if (i_enable) begin
                                r_state <= ST_VSYNC;
                                r_tp    <= i_test_pattern;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_line <= w_line_inc;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // While a request is high the counters already point at the requested pixel.
    assign o_pat_x      = BYTE_W'(r_lc[LCW-1:1]);
    assign o_pat_y      = BYTE_W'(r_line);
    assign o_vsync      = r_vsync;
    assign o_href       = r_href;
    assign o_frame_done = r_done;
    assign o_busy       = r_busy;
    assign o_pix_req    = r_req;
    assign o_tp_mode    = r_tp;

endmodule

// File: rtl/cam_dvp_tx.sv
// DVP camera-source emulator top: frame timing core plus pixel source mux,
// high-byte-first serialiser and stream ready/underflow handling.
module cam_dvp_tx
    import cam_dvp_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_test_pattern,
    cam_dvp_if.slave          pix_if,
    output logic              o_vsync,
    output logic              o_href,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_frame_done,
    output logic              o_underflow,
    output logic              o_busy
);

    logic              w_req;
    logic              w_tp;
    logic [BYTE_W-1:0] w_pat_x;
    logic [BYTE_W-1:0] w_pat_y;
    logic [PIX_W-1:0]  w_pixel;

    logic [BYTE_W-1:0] r_data;
    logic [BYTE_W-1:0] r_lo;
    logic              r_odd;
    logic              r_uf;

    cam_dvp_timing #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) u_timing (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_enable       (i_enable),
        .i_test_pattern (i_test_pattern),
        .o_vsync        (o_vsync),
        .o_href         (o_href),
        .o_frame_done   (o_frame_done),
        .o_busy         (o_busy),
        .o_pix_req      (w_req),
        .o_tp_mode      (w_tp),
        .o_pat_x        (w_pat_x),
        .o_pat_y        (w_pat_y)
    );

    // The upstream stream is only ever offered a handshake in stream mode.
    assign pix_if.pix_ready = w_req & ~w_tp;

    // Pixel source: pattern, accepted stream pixel, or black when the stream starves.
    always_comb begin
        w_pixel = '0;
        if (w_tp) begin
            w_pixel = pattern_pixel(w_pat_y, w_pat_x);
        end else if (pix_if.pix_valid) begin
            w_pixel = pix_if.pix_data;
        end
    end

    // Byte serialiser: high byte on the request edge, held low byte on the next, zero otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
            r_lo   <= '0;
            r_odd  <= 1'b0;
            r_uf   <= 1'b0;
        end else begin
            r_odd <= w_req;
            if (w_req) begin
                r_data <= w_pixel[PIX_W-1:BYTE_W];
                r_lo   <= w_pixel[BYTE_W-1:0];
                if (!w_tp && !pix_if.pix_valid) begin
                    r_uf <= 1'b1;
                end
            end else if (r_odd) begin
                r_data <= r_lo;
            end else begin
                r_data <= '0;
            end
        end
    end

    assign o_data      = r_data;
    assign o_underflow = r_uf;

endmodule

// File: tb/tb_cam_dvp_tx.sv
// Self-checking bench for cam_dvp_tx with small frame timing.
module tb_cam_dvp_tx;

    localparam int HA = 4, VA = 2, HB = 2, VS = 1, VB = 1, VF = 1;
    localparam int LC    = 2 * HA + HB;
    localparam int FRAME = (VS + VB + VA + VF) * LC;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       tp    = 1'b0;
    logic       vsync, href, done, uf, busy;
    logic [7:0] data;

    cam_dvp_if pif();

    cam_dvp_tx #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (en),
        .i_test_pattern (tp),
        .pix_if         (pif.slave),
        .o_vsync        (vsync),
        .o_href         (href),
        .o_data         (data),
        .o_frame_done   (done),
        .o_underflow    (uf),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: position of the visible output within the frame
    // (0..FRAME-1), -1 idle, -2 idle but the next cycle starts a frame.
    int          pos     = -1;
    bit          cont    = 1'b0;
    bit          tp_lat  = 1'b0;
    bit          exp_uf  = 1'b0;
    logic [15:0] q[$];
    logic [15:0] cur_pix = 16'h0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (model pos %0d)", tag, obs, exp, pos);
        end
    endtask

    function automatic bit is_href(input int p);
        int line, col, a;
        if (p < 0 || p >= FRAME) return 1'b0;
        line = p / LC;
        col  = p % LC;
        a    = line - VS - VB;
        return (a >= 0) && (a < VA) && (col < 2 * HA);
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_vsync"}, 16'(vsync), 16'h0);
        chk({tag, "_href"}, 16'(href), 16'h0);
        chk({tag, "_data"}, 16'(data), 16'h0);
        chk({tag, "_ready"}, 16'(pif.pix_ready), 16'h0);
        chk({tag, "_done"}, 16'(done), 16'h0);
        chk({tag, "_uf"}, 16'(uf), 16'h0);
        chk({tag, "_busy"}, 16'(busy), 16'h0);
    endtask

    task automatic model_reset();
        pos     = -1;
        cont    = 1'b0;
        tp_lat  = 1'b0;
        exp_uf  = 1'b0;
        cur_pix = 16'h0;
        q.delete();
    endtask

    // One clock: check outputs against the model, then drive the next inputs.
    task automatic cycle(input bit en_v, input bit tp_v, input int vpct);
        bit          e_vs, e_href, e_rdy, v;
        logic [7:0]  e_data;
        logic [15:0] d;
        int          col, a;
        @(negedge clk);
        e_vs   = (pos >= 0) && (pos / LC < VS);
        e_href = is_href(pos);
        e_data = 8'h00;
        if (e_href) begin
            col = pos % LC;
            a   = pos / LC - VS - VB;
            if (col % 2 == 0) begin
                if (tp_lat) cur_pix = {8'(a), 8'(col / 2)};
                else if (q.size() > 0) cur_pix = q.pop_front();
                else cur_pix = 16'hxxxx;
            end
            e_data = (col % 2 == 0) ? cur_pix[15:8] : cur_pix[7:0];
        end
        e_rdy = !tp_lat && (pos >= 0) && is_href(pos + 1) && (((pos + 1) % LC) % 2 == 0);

        chk("vsync", 16'(vsync), 16'(e_vs));
        chk("href", 16'(href), 16'(e_href));
        chk("data", 16'(data), 16'(e_data));
        chk("ready", 16'(pif.pix_ready), 16'(e_rdy));
        chk("frame_done", 16'(done), 16'(pos == FRAME - 1));
        chk("busy", 16'(busy), 16'(pos >= 0));
        chk("underflow", 16'(uf), 16'(exp_uf));

        en = en_v;
        tp = tp_v;
        v  = ($urandom_range(99) < vpct);
        d  = 16'($urandom);
        pif.pix_valid = v;
        pif.pix_data  = d;
        if (e_rdy) begin
            q.push_back(v ? d : 16'h0000);
            if (!v) exp_uf = 1'b1;
        end

        if (pos == -1 || (pos == FRAME - 1 && !cont)) begin
            if (en_v) begin
                pos    = -2;
                tp_lat = tp_v;
            end else begin
                pos = -1;
            end
        end else if (pos == -2 || pos == FRAME - 1) begin
            pos = 0;
        end else begin
            if (pos == FRAME - 2) begin
                cont = en_v;
                if (en_v) tp_lat = tp_v;
            end
            pos++;
        end
    endtask

    initial begin
        pif.pix_valid = 1'b0;
        pif.pix_data  = 16'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        model_reset();

        // Idle with enable low
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 100);

        // Test pattern, back-to-back frames
        for (int i = 0; i < 2 * FRAME + 5; i++) cycle(1'b1, 1'b1, 100);

        // Switch to stream mid-frame; takes effect at the next frame start
        for (int i = 0; i < 2 * FRAME; i++) cycle(1'b1, 1'b0, 100);

        // Stream with random starvation
        for (int i = 0; i < 3 * FRAME; i++) cycle(1'b1, 1'b0, 70);

        // Reach line 0 of a frame, then drop enable: frame completes, then idle
        for (int i = 0; i < 2 * FRAME && pos != (VS + VB) * LC + 2; i++) cycle(1'b1, 1'b0, 90);
        for (int i = 0; i < FRAME + 10; i++) cycle(1'b0, 1'b0, 90);

        // Restart in stream mode and reset asynchronously mid-line
        for (int i = 0; i < 2 * FRAME && pos != (VS + VB) * LC + 3; i++) cycle(1'b1, 1'b0, 100);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        en = 1'b0;
        tp = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;

        // Stays idle until enabled, then runs a fresh pattern frame
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 100);
        for (int i = 0; i < FRAME + 5; i++) cycle(1'b1, 1'b1, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
